// File: rtl/uart_tx_streamer.sv
// uart_tx_streamer: buffers an 8-bit valid/ready byte stream in a local FIFO
// and drains it into the UART over its register interface. Before each byte
// it polls STATUS until the UART TX FIFO has room, then writes WDATA.

package core_v_mcu_pkg;

  // Register request toward a slave; fields hold steady while valid waits for ready
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  // Register response; ready marks the completing cycle of a transaction
  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

module uart_tx_streamer
  import core_v_mcu_pkg::*;
#(
  parameter int unsigned FifoDepth    = 16,
  parameter logic [31:0] BaseAddr     = 32'h0,
  parameter logic [31:0] StatusOffset = 32'h14,
  parameter logic [31:0] WdataOffset  = 32'h1C,
  parameter int unsigned TxFullBit    = 0,
  parameter int unsigned PollGap      = 8,
  localparam int unsigned LevelW      = $clog2(FifoDepth) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [7:0]        data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output reg_req_t          reg_req_o,
  input  reg_rsp_t          reg_rsp_i,
  output logic [LevelW-1:0] level_o,
  output logic              busy_o,
  output logic              err_o,
  input  logic              err_clr_i
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned GapW = (PollGap > 1) ? $clog2(PollGap) : 1;

  // WAIT counts down from PollGap-1 to 0, giving exactly PollGap WAIT cycles
  localparam logic [GapW-1:0]   GapLoad    = (PollGap > 0) ? GapW'(PollGap - 1) : '0;
  localparam logic [LevelW-1:0] LevelFull  = LevelW'(FifoDepth);
  localparam logic [31:0]       StatusAddr = BaseAddr + StatusOffset;
  localparam logic [31:0]       WdataAddr  = BaseAddr + WdataOffset;

  typedef enum logic [1:0] {
    StIdle,
    StPoll,
    StWrite,
    StWait
  } state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wrPtr_q, wrPtr_d;
  logic [PtrW-1:0]   rdPtr_q, rdPtr_d;
  logic [LevelW-1:0] level_q, level_d;
  logic [GapW-1:0]   gapCnt_q, gapCnt_d;
  logic              err_q, err_d;
  logic [7:0]        mem_q [FifoDepth];

  logic push;
  logic pop;
  logic setErr;
  logic fifoEmpty;
  logic unusedRdata;

  // Only the TX-full bit of STATUS matters; the remaining rdata bits are folded away here
  assign unusedRdata = ^reg_rsp_i.rdata;

  assign fifoEmpty = (level_q == '0);
  assign ready_o   = (level_q != LevelFull);

  // Push on a stream handshake; pop only when the WDATA write is accepted by the slave
  assign push = valid_i && ready_o;
  assign pop  = (state_q == StWrite) && reg_rsp_i.ready;

  // FIFO pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (push) begin
      wrPtr_d = wrPtr_q + PtrW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LevelW'(1);
      2'b01:   level_d = level_q - LevelW'(1);
      default: level_d = level_q;
    endcase
  end

  // Byte storage has no reset: contents are only meaningful between the pointers
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  // Drain sequencer: IDLE decides, POLL reads STATUS, WRITE sends a byte, WAIT backs off
  always_comb begin
    state_d  = state_q;
    gapCnt_d = gapCnt_q;
    setErr   = 1'b0;
    case (state_q)
      StIdle: begin
        // A byte being pushed this very cycle counts, so POLL starts the next cycle
        if (en_i && (!fifoEmpty || push)) begin
          state_d = StPoll;
        end
      end
      StPoll: begin
        if (reg_rsp_i.ready) begin
          if (reg_rsp_i.error) begin
            setErr  = 1'b1;
            state_d = StIdle;
          end else if (reg_rsp_i.rdata[TxFullBit]) begin
            if ((PollGap == 0) || !en_i) begin
              state_d = StIdle;
            end else begin
              state_d  = StWait;
              gapCnt_d = GapLoad;
            end
          end else if (en_i) begin
            state_d = StWrite;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StWrite: begin
        // The byte is consumed even on an error response; it is never retried
        if (reg_rsp_i.ready) begin
          setErr  = reg_rsp_i.error;
          state_d = StIdle;
        end
      end
      StWait: begin
        if (!en_i || (gapCnt_q == '0)) begin
          state_d = StIdle;
        end else begin
          gapCnt_d = gapCnt_q - GapW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Sticky bus-error flag; a new error outranks a clear arriving in the same cycle
  always_comb begin
    err_d = err_q;
    if (setErr) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end
  end

  // All control state, cleared asynchronously so a pending request drops at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      level_q  <= '0;
      gapCnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      level_q  <= level_d;
      gapCnt_q <= gapCnt_d;
      err_q    <= err_d;
    end
  end

  // Bus request decoded from registered state and FIFO head only, so it stays stable while stalled
  always_comb begin
    reg_req_o = '0;
    case (state_q)
      StPoll: begin
        reg_req_o.valid = 1'b1;
        reg_req_o.write = 1'b0;
        reg_req_o.addr  = StatusAddr;
        reg_req_o.wstrb = 4'b0000;
      end
      StWrite: begin
        reg_req_o.valid = 1'b1;
        reg_req_o.write = 1'b1;
        reg_req_o.addr  = WdataAddr;
        reg_req_o.wdata = {24'h0, mem_q[rdPtr_q]};
        reg_req_o.wstrb = 4'b0001;
      end
      default: begin
        reg_req_o = '0;
      end
    endcase
  end

  assign level_o = level_q;
  assign err_o   = err_q;
  assign busy_o  = !fifoEmpty || (state_q == StPoll) || (state_q == StWrite);

endmodule

// File: tb/tb_uart_tx_streamer.sv
// tb_uart_tx_streamer: drives byte streams into uart_tx_streamer, plays a
// UART register slave with configurable stalls, full-STATUS answers and
// error injection, and scoreboards every WDATA write against the bytes
// accepted by a queue-based model of the FIFO.

module tb_uart_tx_streamer;
  import core_v_mcu_pkg::*;

  localparam int unsigned Depth      = 16;
  localparam int unsigned Gap        = 8;
  localparam logic [31:0] StatusAddr = 32'h14;
  localparam logic [31:0] WdataAddr  = 32'h1C;

  logic       clock;
  logic       rstN;
  logic       en;
  logic [7:0] dataIn;
  logic       validIn;
  logic       ready;
  reg_req_t   req;
  reg_rsp_t   rsp;
  logic [4:0] level;
  logic       busy;
  logic       err;
  logic       errClr;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: accepted bytes in arrival order, occupancy and error flag
  logic [7:0] expQ[$];
  int         modelLevel = 0;
  logic       modelErr   = 1'b0;

  // Slave behaviour knobs and per-transaction bookkeeping
  int         pollStall  = 0;
  int         writeStall = 0;
  int         fullPolls  = 0;
  logic       randomBus  = 1'b0;
  logic       errArm     = 1'b0;
  logic [7:0] errByte    = 8'h00;
  logic       inTxn      = 1'b0;
  int         waitCnt    = 0;
  int         curStall   = 0;
  reg_req_t   heldReq;
  logic       pollOk     = 1'b0;
  int         errCompCyc = -1;

  int pollStarts[$];
  int writeStarts[$];
  int writeDones[$];

  uart_tx_streamer #(
    .FifoDepth   (Depth),
    .BaseAddr    (32'h0),
    .StatusOffset(32'h14),
    .WdataOffset (32'h1C),
    .TxFullBit   (0),
    .PollGap     (Gap)
  ) dut (
    .clk_i    (clock),
    .rst_ni   (rstN),
    .en_i     (en),
    .data_i   (dataIn),
    .valid_i  (validIn),
    .ready_o  (ready),
    .reg_req_o(req),
    .reg_rsp_i(rsp),
    .level_o  (level),
    .busy_o   (busy),
    .err_o    (err),
    .err_clr_i(errClr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Presents one byte for one cycle; called just after a rising edge
  task automatic applyStimulus(input logic [7:0] b);
    dataIn  = b;
    validIn = 1'b1;
    @(posedge clock);
    #1;
    validIn = 1'b0;
  endtask

  task automatic waitWrites(input int target, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (writeDones.size() >= target) break;
      @(posedge clock);
      #1;
    end
    checkOutput(name, 32'(writeDones.size() >= target), 32'd1);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor, slave and model, all evaluated mid-cycle away from the active edge
  always @(negedge clock) begin : monitorProc
    logic [7:0] expByte;
    logic       full;
    logic       complete;
    logic       compErr;
    logic       doPush;
    complete = 1'b0;
    compErr  = 1'b0;
    if (!rstN) begin
      checkOutput("rstReqZero", 32'(req == '0), 32'd1);
      checkOutput("rstReady", 32'(ready), 32'd1);
      checkOutput("rstLevel", 32'(level), 32'd0);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstErr", 32'(err), 32'd0);
      modelLevel = 0;
      expQ.delete();
      modelErr = 1'b0;
      inTxn    = 1'b0;
      waitCnt  = 0;
      pollOk   = 1'b0;
      rsp      = '0;
    end else begin
      checkOutput("level", 32'(level), 32'(modelLevel));
      checkOutput("ready", 32'(ready), 32'(modelLevel < Depth));
      checkOutput("err", 32'(err), 32'(modelErr));

      rsp = '0;
      if (req.valid) begin
        if (!inTxn) begin
          inTxn    = 1'b1;
          waitCnt  = 0;
          heldReq  = req;
          curStall = randomBus ? int'($urandom_range(0, 3)) : (req.write ? writeStall : pollStall);
          if (req.write) begin
            writeStarts.push_back(cyc);
            checkOutput("writeAfterClearPoll", 32'(pollOk), 32'd1);
            pollOk = 1'b0;
            checkOutput("writeAddr", req.addr, WdataAddr);
            checkOutput("writeStrb", 32'(req.wstrb), 32'h1);
          end else begin
            pollStarts.push_back(cyc);
            checkOutput("pollAddr", req.addr, StatusAddr);
            checkOutput("pollStrb", 32'(req.wstrb), 32'h0);
          end
        end else begin
          checkOutput("reqStable", 32'(req == heldReq), 32'd1);
        end

        if (waitCnt < curStall) begin
          waitCnt++;
        end else begin
          rsp.ready = 1'b1;
          complete  = 1'b1;
          inTxn     = 1'b0;
          if (req.write) begin
            writeDones.push_back(cyc);
            checkOutput("writeExpected", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
              expByte = expQ.pop_front();
              checkOutput("wdata", req.wdata, {24'h0, expByte});
            end
            if (errArm && (req.wdata[7:0] == errByte)) begin
              rsp.error  = 1'b1;
              errArm     = 1'b0;
              compErr    = 1'b1;
              errCompCyc = cyc;
            end
          end else begin
            if (randomBus) begin
              full = ($urandom_range(0, 3) == 0);
            end else begin
              full = (fullPolls > 0);
              if (fullPolls > 0) fullPolls--;
            end
            rsp.rdata    = $urandom;
            rsp.rdata[0] = full;
            pollOk       = !full;
          end
        end
      end else begin
        if (inTxn) begin
          checkOutput("validHeld", 32'(req.valid), 32'd1);
        end
        inTxn = 1'b0;
      end

      // Apply what the coming edge will do to the model
      doPush = validIn && (modelLevel < Depth);
      if (complete && req.write) modelLevel--;
      if (doPush) begin
        expQ.push_back(dataIn);
        modelLevel++;
      end
      if (compErr) begin
        modelErr = 1'b1;
      end else if (errClr) begin
        modelErr = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int p0;
    int w0;
    rstN    = 1'b0;
    en      = 1'b0;
    validIn = 1'b0;
    dataIn  = 8'h00;
    errClr  = 1'b0;
    rsp     = '0;
    repeat (3) @(posedge clock);
    #1;
    rstN = 1'b1;
    en   = 1'b1;

    // Single byte, zero-wait slave: POLL at N+1, WRITE at N+2, level 0 at N+3
    waitCycles(1);
    p0 = pollStarts.size();
    w0 = writeDones.size();
    n  = cyc;
    applyStimulus(8'h41);
    checkOutput("t1PollValid", 32'(req.valid && !req.write), 32'd1);
    checkOutput("t1BusyInPoll", 32'(busy), 32'd1);
    waitWrites(w0 + 1, 20, "t1WriteSeen");
    if (writeDones.size() > w0 && pollStarts.size() > p0) begin
      checkOutput("t1PollCycle", 32'(pollStarts[p0]), 32'(n + 1));
      checkOutput("t1WriteCycle", 32'(writeStarts[w0]), 32'(n + 2));
    end
    waitCycles(2);
    checkOutput("t1BusyLow", 32'(busy), 32'd0);

    // Fill with drain disabled: 16 accepted, 17th refused, then drain in order
    en = 1'b0;
    w0 = writeDones.size();
    for (int i = 0; i < 17; i++) begin
      dataIn  = 8'($urandom);
      validIn = 1'b1;
      @(posedge clock);
      #1;
    end
    validIn = 1'b0;
    checkOutput("t2LevelFull", 32'(level), 32'd16);
    checkOutput("t2ReadyLow", 32'(ready), 32'd0);
    en = 1'b1;
    waitWrites(w0 + 16, 120, "t2DrainSixteen");
    waitCycles(3);
    checkOutput("t2WriteCount", 32'(writeDones.size() - w0), 32'd16);
    checkOutput("t2LevelEmpty", 32'(level), 32'd0);

    // TX full for three polls: four POLLs ten cycles apart, then one WRITE
    fullPolls = 3;
    p0 = pollStarts.size();
    w0 = writeDones.size();
    applyStimulus(8'h3C);
    waitWrites(w0 + 1, 100, "t3WriteSeen");
    checkOutput("t3PollCount", 32'(pollStarts.size() - p0), 32'd4);
    if (pollStarts.size() - p0 == 4 && writeStarts.size() > w0) begin
      for (int i = 1; i < 4; i++) begin
        checkOutput("t3PollSpacing", 32'(pollStarts[p0 + i] - pollStarts[p0 + i - 1]), 32'd10);
      end
      checkOutput("t3WriteAfterPoll", 32'(writeStarts[w0] - pollStarts[p0 + 3]), 32'd1);
    end

    // Slave stalls the WRITE for five cycles: six-cycle transaction, stable fields
    writeStall = 5;
    w0 = writeDones.size();
    applyStimulus(8'hA7);
    waitWrites(w0 + 1, 40, "t4WriteSeen");
    if (writeDones.size() > w0) begin
      checkOutput("t4WriteLength", 32'(writeDones[w0] - writeStarts[w0]), 32'd5);
    end
    writeStall = 0;
    waitCycles(2);

    // Error on the 0x55 write: flag sets, byte dropped, next byte still sent
    errByte = 8'h55;
    errArm  = 1'b1;
    w0 = writeDones.size();
    applyStimulus(8'h55);
    applyStimulus(8'h66);
    waitWrites(w0 + 2, 40, "t5BothWritten");
    checkOutput("t5ErrSet", 32'(err), 32'd1);
    errClr = 1'b1;
    waitCycles(1);
    errClr = 1'b0;
    checkOutput("t5ErrCleared", 32'(err), 32'd0);

    // Error completing while clear is held: the set wins
    errClr     = 1'b1;
    errByte    = 8'h77;
    errArm     = 1'b1;
    errCompCyc = -1;
    applyStimulus(8'h77);
    for (int i = 0; i < 40; i++) begin
      if (errCompCyc >= 0) break;
      @(posedge clock);
      #1;
    end
    checkOutput("t5ErrorIssued", 32'(errCompCyc >= 0), 32'd1);
    checkOutput("t5SetWins", 32'(err), 32'd1);
    errClr = 1'b0;
    waitCycles(1);
    checkOutput("t5StillSet", 32'(err), 32'd1);
    errClr = 1'b1;
    waitCycles(1);
    errClr = 1'b0;

    // Enable dropped during a stalled POLL: POLL finishes, no WRITE follows
    pollStall = 4;
    p0 = pollStarts.size();
    w0 = writeStarts.size();
    applyStimulus(8'h12);
    for (int i = 0; i < 20; i++) begin
      if (pollStarts.size() > p0) break;
      @(posedge clock);
      #1;
    end
    en = 1'b0;
    checkOutput("t6PollStarted", 32'(pollStarts.size() > p0), 32'd1);
    waitCycles(20);
    checkOutput("t6NoWrite", 32'(writeStarts.size()), 32'(w0));
    checkOutput("t6LevelHeld", 32'(level), 32'd1);
    checkOutput("t6ReqIdle", 32'(req.valid), 32'd0);
    checkOutput("t6BusyWithData", 32'(busy), 32'd1);
    pollStall = 0;

    // Reset in the middle of a stalled WRITE: request and FIFO clear at once
    writeStall = 5;
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (writeStarts.size() > w0) break;
      @(posedge clock);
      #1;
    end
    checkOutput("t6WriteStarted", 32'(writeStarts.size() > w0), 32'd1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("t6RstReqDrop", 32'(req.valid), 32'd0);
    checkOutput("t6RstLevel", 32'(level), 32'd0);
    writeStall = 0;
    waitCycles(2);
    rstN = 1'b1;
    waitCycles(1);

    // Randomised traffic with random stalls, random full STATUS and toggling enable
    randomBus = 1'b1;
    w0 = writeDones.size();
    for (int i = 0; i < 400; i++) begin
      validIn = 1'($urandom_range(0, 1));
      dataIn  = 8'($urandom);
      en      = ($urandom_range(0, 9) != 0);
      @(posedge clock);
      #1;
    end
    validIn = 1'b0;
    en      = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (!busy) break;
      @(posedge clock);
      #1;
    end
    checkOutput("randDrained", 32'(busy), 32'd0);
    checkOutput("randQueueEmpty", 32'(expQ.size()), 32'd0);
    checkOutput("randSomeWrites", 32'(writeDones.size() > w0 + 20), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_streamer.md
# uart_tx_streamer

Upstream feeder for `uart_subsystem`: accepts a byte stream (valid/ready), buffers it in a local FIFO, and drains it into the UART by mastering the UART register interface (`core_v_mcu_pkg::reg_req_t`/`reg_rsp_t`). For each byte it polls the UART STATUS register until TX-FIFO-full is clear, then writes WDATA. This offloads console/log traffic from the CPU; the block sits between a stream producer and a bus demux port toward `uart_reg_req`.

## Interface
- `FifoDepth`, 16: local byte FIFO entries; power of two, ≥2.
- `BaseAddr`, 32'h0: UART register base address.
- `StatusOffset`, 32'h14: STATUS register byte offset.
- `WdataOffset`, 32'h1C: WDATA register byte offset.
- `TxFullBit`, 0: STATUS bit index meaning "UART TX FIFO full".
- `PollGap`, 8: idle cycles between a STATUS read returning full and the next poll; 0 allowed.
- `clk_i`  in  1  clock, single domain.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `en_i`  in  1  drain enable; FIFO still accepts bytes when low.
- `data_i`  in  8  stream byte.
- `valid_i`  in  1  stream valid.
- `ready_o`  out  1  stream ready (= FIFO not full).
- `reg_req_o`  out  reg_req_t  register request toward UART (addr, write, wdata, wstrb, valid).
- `reg_rsp_i`  in  reg_rsp_t  register response (rdata, error, ready).
- `level_o`  out  $clog2(FifoDepth)+1  current FIFO occupancy.
- `busy_o`  out  1  FIFO non-empty or bus transaction in flight.
- `err_o`  out  1  sticky bus-error flag.
- `err_clr_i`  in  1  clears `err_o`.

## Operation
- FIFO: push on `valid_i && ready_o`; pop only on WDATA write completion. Simultaneous push and pop leave `level_o` unchanged. Pointers wrap modulo `FifoDepth`; `level_o` ranges 0..FifoDepth.
- FSM states: IDLE, POLL, WRITE, WAIT.
  - IDLE: if `en_i` and level>0 -> POLL.
  - POLL: `valid=1, write=0, addr=BaseAddr+StatusOffset, wstrb=0`. On `ready`: if `error` -> set err, go IDLE; else if `rdata[TxFullBit]` -> WAIT (or IDLE directly if PollGap=0); else -> WRITE.
  - WRITE: `valid=1, write=1, addr=BaseAddr+WdataOffset, wdata={24'h0, head byte}, wstrb=4'b0001`. On `ready`: pop; if `error` set err (byte is dropped, not retried); go IDLE.
  - WAIT: count PollGap cycles, then IDLE.
- Bus rule: once `valid` is asserted, addr/write/wdata/wstrb and `valid` remain stable until the cycle `ready` is high; the transaction completes in that cycle. `valid` is never dropped while waiting.
- `en_i` low: a transaction in progress completes normally, then the FSM stays in IDLE. WAIT is abandoned to IDLE immediately.
- `err_o`: set on any `error` response, cleared by `err_clr_i`; a set and a clear in the same cycle -> set wins.
- `busy_o` = (level>0) || (state∈{POLL, WRITE}).

## Timing
- Reset values: `ready_o=1`, `reg_req_o` all-zero (`valid=0`), `level_o=0`, `busy_o=0`, `err_o=0`; FSM in IDLE, FIFO empty.
- Byte pushed at cycle N with FSM idle and `en_i=1`: POLL `valid` rises at N+1. With zero-wait `ready`, the WRITE request is at N+2 and the pop is visible on `level_o` at N+3.
- Steady state, zero-wait bus, UART not full: 2 cycles per byte plus 1 IDLE cycle = 3 cycles/byte.
- Full poll retry interval: POLL completion -> PollGap WAIT cycles -> 1 IDLE -> next POLL.
- `ready_o` is a registered-state function (no combinational path from `valid_i`). `reg_req_o` is driven from registered state and FIFO head only, with no combinational path from `reg_rsp_i`.
- Asynchronous reset mid-transaction: the request drops immediately and FIFO contents are lost.

## Test plan
- Single byte 0x41, `en_i=1`, UART STATUS=0, zero-wait: POLL at cycle 1, WRITE addr=Base+0x1C wdata=0x41 wstrb=0001 at cycle 2, `level_o` back to 0 at cycle 3, `busy_o` low after.
- Fill with `en_i=0`: push 17 bytes with FifoDepth=16 -> `ready_o` low after 16, `level_o=16`, 17th byte not accepted. Raise `en_i` -> 16 writes in order, FIFO pointers wrap correctly.
- STATUS returns txfull for 3 polls, PollGap=8: exactly 4 POLLs spaced 10 cycles apart, then one WRITE; no WRITE while full.
- Slave stalls `ready` low for 5 cycles in WRITE: request fields are stable for all 6 cycles, pop occurs only in the ready cycle.
- `error` on WRITE of byte 0x55: `err_o=1`, byte dropped, next byte proceeds; `err_clr_i` pulse clears it; `error` coincident with `err_clr_i` keeps `err_o=1`.
- `en_i` dropped during a stalled POLL: POLL completes, no WRITE issued, FSM holds IDLE with level unchanged. Reset asserted mid-WRITE: `reg_req_o.valid=0` immediately and `level_o=0`.
